// File: rtl/set_host.sv
// Host-side sequencer for the SET engine: buffers test patterns, issues them one at a time
// over the en/busy/valid handshake and tallies matching and mismatching results.
`timescale 1ns/1ps
module set_host #(
    parameter int unsigned NUM_PAT = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_en_i,
    input  logic [23:0]      ld_central_i,
    input  logic [11:0]      ld_radius_i,
    input  logic [1:0]       ld_mode_i,
    input  logic [7:0]       ld_expect_i,
    input  logic             start_i,
    output logic             en_o,
    output logic [23:0]      central_o,
    output logic [11:0]      radius_o,
    output logic [1:0]       mode_o,
    input  logic             busy_i,
    input  logic             valid_i,
    input  logic [7:0]       candidate_i,
    output logic             running_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    localparam int unsigned      AW        = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int unsigned      TW        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] NUM_PAT_C = CNT_W'(NUM_PAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Firing one count early makes timeout_o rise exactly TIMEOUT cycles after en_o.
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitValid,
        StFinish
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] idx;
    logic [TW-1:0]    tcnt;

    logic [23:0] mem_central [NUM_PAT];
    logic [11:0] mem_radius  [NUM_PAT];
    logic [1:0]  mem_mode    [NUM_PAT];
    logic [7:0]  mem_expect  [NUM_PAT];

    logic             ld_acc;
    logic [CNT_W-1:0] idx_nxt;
    logic             result_ok;

    assign ld_acc    = (state == StIdle) && ld_en_i && (wr_ptr < NUM_PAT_C);
    assign idx_nxt   = idx + 1'b1;
    assign result_ok = (candidate_i == mem_expect[idx[AW-1:0]]);
    assign en_o      = (state == StIssue);
    assign running_o = (state != StIdle);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (ld_acc) begin
            mem_central[wr_ptr[AW-1:0]] <= ld_central_i;
            mem_radius[wr_ptr[AW-1:0]]  <= ld_radius_i;
            mem_mode[wr_ptr[AW-1:0]]    <= ld_mode_i;
            mem_expect[wr_ptr[AW-1:0]]  <= ld_expect_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= StIdle;
            wr_ptr     <= '0;
            run_len    <= '0;
            idx        <= '0;
            tcnt       <= '0;
            central_o  <= '0;
            radius_o   <= '0;
            mode_o     <= '0;
            done_o     <= 1'b0;
            mismatch_o <= 1'b0;
            timeout_o  <= 1'b0;
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
        end else begin
            done_o     <= 1'b0;
            mismatch_o <= 1'b0;
            if (ld_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (start_i) begin
                        idx        <= '0;
                        pass_cnt_o <= '0;
                        fail_cnt_o <= '0;
                        timeout_o  <= 1'b0;
                        run_len    <= wr_ptr + {{(CNT_W-1){1'b0}}, ld_acc};
                        if (wr_ptr == '0 && !ld_acc) begin
                            state  <= StFinish;
                            done_o <= 1'b1;
                        end else begin
                            state <= StIssue;
                            // The first pattern may be the one being written this very cycle.
                            if (wr_ptr == '0) begin
                                central_o <= ld_central_i;
                                radius_o  <= ld_radius_i;
                                mode_o    <= ld_mode_i;
                            end else begin
                                central_o <= mem_central[0];
                                radius_o  <= mem_radius[0];
                                mode_o    <= mem_mode[0];
                            end
                        end
                    end
                end
                StIssue: begin
                    tcnt  <= '0;
                    state <= StWaitBusy;
                end
                StWaitBusy, StWaitValid: begin
                    tcnt <= tcnt + 1'b1;
                    if (state == StWaitValid && valid_i && !busy_i) begin
                        if (result_ok) begin
                            pass_cnt_o <= sat_inc(pass_cnt_o);
                        end else begin
                            fail_cnt_o <= sat_inc(fail_cnt_o);
                            mismatch_o <= 1'b1;
                        end
                        idx <= idx_nxt;
                        if (idx_nxt == run_len) begin
                            state  <= StFinish;
                            done_o <= 1'b1;
                        end else begin
                            state     <= StIssue;
                            central_o <= mem_central[idx_nxt[AW-1:0]];
                            radius_o  <= mem_radius[idx_nxt[AW-1:0]];
                            mode_o    <= mem_mode[idx_nxt[AW-1:0]];
                        end
                    end else if (tcnt == TO_LAST) begin
                        timeout_o  <= 1'b1;
                        fail_cnt_o <= sat_inc(fail_cnt_o);
                        state      <= StFinish;
                        done_o     <= 1'b1;
                    end else if (state == StWaitBusy && busy_i) begin
                        state <= StWaitValid;
                    end
                end
                StFinish: begin
                    wr_ptr <= '0;
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_set_host.sv
// Bench for set_host: an engine model answers each en_o pulse, and a pattern-queue model
// predicts issue times, presented data, tallies and flags for each run.
`timescale 1ns/1ps
module tb_set_host;

    localparam int NUM_PAT = 8;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 32;
    localparam int PERIOD  = 20;

    typedef struct packed {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic [7:0]  e;
    } pat_t;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             ld_en_i = 1'b0;
    logic [23:0]      ld_central_i = '0;
    logic [11:0]      ld_radius_i = '0;
    logic [1:0]       ld_mode_i = '0;
    logic [7:0]       ld_expect_i = '0;
    logic             start_i = 1'b0;
    logic             en_o;
    logic [23:0]      central_o;
    logic [11:0]      radius_o;
    logic [1:0]       mode_o;
    logic             busy_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [7:0]       candidate_i = '0;
    logic             running_o;
    logic             done_o;
    logic             mismatch_o;
    logic             timeout_o;
    logic [CNT_W-1:0] pass_cnt_o;
    logic [CNT_W-1:0] fail_cnt_o;

    set_host #(.NUM_PAT(NUM_PAT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ld_en_i(ld_en_i), .ld_central_i(ld_central_i),
        .ld_radius_i(ld_radius_i), .ld_mode_i(ld_mode_i), .ld_expect_i(ld_expect_i),
        .start_i(start_i), .en_o(en_o), .central_o(central_o), .radius_o(radius_o),
        .mode_o(mode_o), .busy_i(busy_i), .valid_i(valid_i), .candidate_i(candidate_i),
        .running_o(running_o), .done_o(done_o), .mismatch_o(mismatch_o),
        .timeout_o(timeout_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    pat_t        m_pats[$];     // patterns the buffer should hold
    logic [7:0]  exp_resp[$];   // engine answer for each held pattern
    logic [7:0]  eng_resp[$];
    bit          eng_silent = 1'b0;
    int          en_cyc_q[$];
    logic [37:0] en_pat_q[$];
    int          mm_cnt = 0;
    int          to_cyc = -1;

    // Engine: busy for 18 cycles after en, then valid held until the next en.
    int          since = 0;
    bit          active = 1'b0;
    logic [7:0]  cur = '0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            active = 1'b0; busy_i = 1'b0; valid_i = 1'b0; candidate_i = '0;
        end else if (en_o) begin
            active = 1'b1; since = 0; busy_i = 1'b0; valid_i = 1'b0;
            cur = (eng_resp.size() > 0) ? eng_resp.pop_front() : 8'h00;
        end else if (active) begin
            since++;
            busy_i = (since >= 1 && since <= 18);
            if (since == 19 && !eng_silent) begin
                valid_i = 1'b1; candidate_i = cur;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (en_o) begin
                en_cyc_q.push_back(cyc);
                en_pat_q.push_back({central_o, radius_o, mode_o});
            end
            if (mismatch_o) mm_cnt++;
            if (timeout_o && to_cyc < 0) to_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pat_t rand_pat();
        pat_t p;
        p.c = 24'($urandom);
        p.r = 12'($urandom);
        p.m = 2'($urandom);
        p.e = 8'($urandom);
        return p;
    endfunction

    task automatic load(input pat_t p, input logic [7:0] rsp);
        @(negedge clk_i);
        ld_en_i = 1'b1; ld_central_i = p.c; ld_radius_i = p.r;
        ld_mode_i = p.m; ld_expect_i = p.e;
        if (m_pats.size() < NUM_PAT) begin
            m_pats.push_back(p); exp_resp.push_back(rsp);
        end
        @(negedge clk_i);
        ld_en_i = 1'b0;
    endtask

    task automatic do_run(input string nm, input bit co_ld, input pat_t cp,
                          input logic [7:0] crsp, input bit silent);
        pat_t       run_pats[$];
        logic [7:0] rsp[$];
        int n_exp, exp_pass, exp_fail, t0, n, exp_done, done_cyc;
        eng_silent = silent;
        en_cyc_q.delete(); en_pat_q.delete(); mm_cnt = 0; to_cyc = -1;
        @(negedge clk_i);
        start_i = 1'b1; t0 = cyc;
        if (co_ld) begin
            ld_en_i = 1'b1; ld_central_i = cp.c; ld_radius_i = cp.r;
            ld_mode_i = cp.m; ld_expect_i = cp.e;
            if (m_pats.size() < NUM_PAT) begin
                m_pats.push_back(cp); exp_resp.push_back(crsp);
            end
        end
        run_pats = m_pats; rsp = exp_resp; eng_resp = exp_resp;
        @(negedge clk_i);
        start_i = 1'b0; ld_en_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < 3000) begin
            @(negedge clk_i); n++;
        end
        done_cyc = cyc;
        chk({nm, ":done_seen"}, 64'(done_o), 64'(1));
        @(negedge clk_i);
        n_exp = silent ? ((run_pats.size() > 0) ? 1 : 0) : run_pats.size();
        exp_pass = 0; exp_fail = 0;
        if (silent) exp_fail = n_exp;
        else foreach (run_pats[i]) if (rsp[i] == run_pats[i].e) exp_pass++; else exp_fail++;
        if (n_exp == 0) exp_done = t0 + 1;
        else if (silent) exp_done = t0 + 1 + TIMEOUT;
        else exp_done = t0 + 1 + PERIOD * n_exp;
        chk({nm, ":en_count"}, 64'(en_cyc_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < en_cyc_q.size(); i++) begin
            chk($sformatf("%s:en_cycle%0d", nm, i), 64'(en_cyc_q[i] - t0), 64'(1 + PERIOD * i));
            chk($sformatf("%s:en_data%0d", nm, i), 64'(en_pat_q[i]),
                64'({run_pats[i].c, run_pats[i].r, run_pats[i].m}));
        end
        chk({nm, ":done_cycle"}, 64'(done_cyc - t0), 64'(exp_done - t0));
        chk({nm, ":pass"}, 64'(pass_cnt_o), 64'(exp_pass));
        chk({nm, ":fail"}, 64'(fail_cnt_o), 64'(exp_fail));
        chk({nm, ":mismatch_pulses"}, 64'(mm_cnt), 64'(silent ? 0 : exp_fail));
        chk({nm, ":timeout"}, 64'(timeout_o), 64'(silent && n_exp > 0));
        if (silent && n_exp > 0) chk({nm, ":timeout_cycle"}, 64'(to_cyc - t0), 64'(1 + TIMEOUT));
        chk({nm, ":running_after"}, 64'(running_o), 64'(0));
        m_pats.delete(); exp_resp.delete();
        eng_silent = 1'b0;
    endtask

    initial begin
        pat_t p;
        logic [7:0] r;
        repeat (3) @(negedge clk_i);
        chk("rst:outputs", {en_o, running_o, done_o, mismatch_o, timeout_o, pass_cnt_o,
            fail_cnt_o, central_o, radius_o, mode_o}, 64'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle:running", 64'(running_o), 64'(0));

        // Single pass
        p = rand_pat(); p.e = 8'd5;
        load(p, 8'd5);
        do_run("single", 1'b0, p, 8'd0, 1'b0);

        // Back-to-back: pattern 4 answers 3 instead of 4
        for (int i = 0; i < NUM_PAT; i++) begin
            p = rand_pat(); p.e = 8'(i);
            load(p, (i == 4) ? 8'd3 : 8'(i));
        end
        do_run("b2b", 1'b0, p, 8'd0, 1'b0);

        // Full buffer: nine random loads, ninth is dropped
        for (int i = 0; i < NUM_PAT + 1; i++) begin
            p = rand_pat();
            r = ($urandom_range(0, 2) == 0) ? p.e + 8'd1 : p.e;
            load(p, r);
        end
        do_run("full", 1'b0, p, 8'd0, 1'b0);

        // Same-cycle load and start with two already loaded
        for (int i = 0; i < 2; i++) begin
            p = rand_pat(); load(p, p.e);
        end
        p = rand_pat();
        do_run("co_load", 1'b1, p, p.e ^ 8'h80, 1'b0);

        // Timeout, then an empty run clears the flag
        p = rand_pat(); load(p, p.e);
        do_run("timeout", 1'b0, p, 8'd0, 1'b1);
        do_run("tmo_clear", 1'b0, p, 8'd0, 1'b0);

        // Random-length runs
        for (int k = 0; k < 3; k++) begin
            int len;
            len = $urandom_range(1, NUM_PAT);
            for (int i = 0; i < len; i++) begin
                p = rand_pat();
                r = ($urandom_range(0, 1) == 0) ? p.e ^ 8'(1 + $urandom_range(0, 254)) : p.e;
                load(p, r);
            end
            do_run($sformatf("rand%0d", k), 1'b0, p, 8'd0, 1'b0);
        end

        // Reset while waiting for valid
        p = rand_pat(); p.c[0] = 1'b1; load(p, p.e);
        @(negedge clk_i); start_i = 1'b1; eng_resp = exp_resp;
        @(negedge clk_i); start_i = 1'b0;
        repeat (12) @(negedge clk_i);
        chk("rst_mid:pre_running", 64'(running_o), 64'(1));
        rst_i = 1'b1;
        #1;
        chk("rst_mid:outputs", {en_o, running_o, done_o, mismatch_o, timeout_o, pass_cnt_o,
            fail_cnt_o, central_o, radius_o, mode_o}, 64'(0));
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        m_pats.delete(); exp_resp.delete(); en_cyc_q.delete();
        repeat (25) @(negedge clk_i);
        chk("rst_mid:no_en_after", 64'(en_cyc_q.size()), 64'(0));
        do_run("rst_empty", 1'b0, p, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/set_host.md
# set_host

Host-side sequencer for the SET engine. It buffers up to NUM_PAT test patterns, each with its expected candidate count, and issues them one at a time with a single-cycle `en` pulse. For each pattern it waits for the engine's busy/valid handshake, compares the returned candidate against the expected value, and keeps pass/fail tallies. It sits opposite the SET controller on the `en`/`busy`/`valid` interface and drives the engine in self-checking runs on the board.

## Interface
- NUM_PAT, 8: pattern buffer depth.
- CNT_W, 4: width of the write pointer, issue index and tallies; must satisfy 2^CNT_W > NUM_PAT.
- TIMEOUT, 32: maximum cycles per pattern from the `en_o` cycle to `valid_i`.

Clock and reset: clk_i, with rst_i asynchronous and active-high.

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- ld_en_i  in  1  write one pattern into the buffer
- ld_central_i  in  24  pattern central coordinates
- ld_radius_i  in  12  pattern radii
- ld_mode_i  in  2  pattern mode
- ld_expect_i  in  8  expected candidate count
- start_i  in  1  begin a run over all loaded patterns
- en_o  out  1  engine enable pulse
- central_o  out  24  to engine
- radius_o  out  12  to engine
- mode_o  out  2  to engine
- busy_i  in  1  engine busy
- valid_i  in  1  engine result valid; the engine holds it high until the next `en`
- candidate_i  in  8  engine result
- running_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at the end of a run
- mismatch_o  out  1  one-cycle pulse when a result differs from its expected value
- timeout_o  out  1  sticky; cleared by the next accepted start
- pass_cnt_o  out  CNT_W  passing patterns in the current or last run
- fail_cnt_o  out  CNT_W  failing patterns in the current or last run

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_VALID, FINISH.
- **Loading**
  - `ld_en_i` is accepted only in IDLE and only while the buffer count is below NUM_PAT.
  - An accepted write stores {central, radius, mode, expect} at the write pointer, then increments the pointer.
  - Writes while full or while not in IDLE are dropped silently.
- **IDLE**
  - `start_i=1` moves to ISSUE. The run length is the buffer count including any write accepted in the same cycle.
  - If that run length is 0, go straight to FINISH instead.
  - An accepted start clears the issue index, both tallies and `timeout_o`.
- **ISSUE**
  - `en_o=1` for exactly this one cycle, then go to WAIT_BUSY.
  - `central_o`, `radius_o` and `mode_o` present pattern[idx] in this cycle and hold until the next ISSUE.
  - The timeout counter clears here.
- **WAIT_BUSY**: on `busy_i=1`, go to WAIT_VALID. A `valid_i` that is still high from the previous result is ignored here.
- **WAIT_VALID**: on `valid_i=1` with `busy_i=0`:
  - Compare `candidate_i` against the expected value.
  - On a match, increment `pass_cnt_o`. Otherwise increment `fail_cnt_o` and pulse `mismatch_o` in the next cycle.
  - Increment idx.
  - If idx+1 equals the run length, go to FINISH; otherwise go to ISSUE.
- **Timeout**
  - The counter increments every cycle in WAIT_BUSY and WAIT_VALID.
  - On reaching TIMEOUT, set `timeout_o`, count the pattern as a fail and go to FINISH. No further patterns are issued.
- **FINISH**
  - Pulse `done_o`, clear the write pointer (the buffer is emptied), return to IDLE.
  - The tallies hold until the next accepted start.
- Tallies saturate at 2^CNT_W−1.
- **Reset at any time**
  - Every output is 0, including `en_o`, the data outputs, the tallies and the flags.
  - State returns to IDLE, and the pointer, index and timeout counter clear.
  - Buffer contents are don't-care.

## Timing
- Start to first `en_o`: `start_i` is sampled in cycle 0 and `en_o` is high in cycle 1.
- Engine response relative to `en_o` in cycle E:
  - `busy_i` is high from E+1 to E+18.
  - `valid_i` is first high in E+19, which is the cycle the compare happens.
- Back-to-back patterns: the next `en_o` is in E+20, giving a steady-state period of 20 cycles per pattern.
- Run completion: `done_o` is high in the cycle after the last compare.
- `mismatch_o`: high in the cycle after the failing compare.
- Control outputs are decoded from registered state. `mismatch_o`, `done_o` and the data outputs are registered, so there are no combinational paths from the inputs.

## Test plan
- **Reset**: assert rst_i mid-WAIT_VALID -> all outputs 0 in the same cycle, `en_o` stays 0 afterwards, the next `start_i` with no loads gives `done_o` one cycle later with tallies 0.
- **Single pass**: load one pattern with expect=5, start, engine model returns 5 -> `en_o` at cycle 1, compare at cycle 20, `done_o` at cycle 21, pass=1, fail=0, no `mismatch_o`.
- **Back-to-back run**: load 8 patterns with expected values 0..7, model returns 3 where 4 was expected on pattern 4 -> `en_o` pulses 20 cycles apart, one `mismatch_o`, pass=7, fail=1.
- **Full buffer**: issue 9 loads -> the 9th is dropped; the run issues exactly 8 `en_o` pulses.
- **Same-cycle load and start**: `ld_en_i` and `start_i` high together with 2 already loaded -> 3 patterns issued.
- **Timeout**: the model never raises `valid_i` -> `timeout_o`=1 32 cycles after `en_o`, fail=1, `done_o` pulses, and the next start clears `timeout_o`.
